serial_shift_unit: RTL

//   Multi-cycle ARM operand-2 shifter: LSL, LSR, ASR or ROR of a WIDTH-bit operand by a variable amount.

---
 rtl/serial_shift_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_shift_unit.sv
// serial_shift_unit
//   Multi-cycle ARM operand-2 shifter. Applies LSL, LSR, ASR or ROR to a
//   WIDTH-bit operand one bit per clock and produces the ARM shifter carry-out.
//   It sits between register read (producer) and the ALU operand-B mux
//   (consumer). Both sides use a valid/ready handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request; start_ready high
//   SHIFT  | one 1-bit shift per edge until the count is exhausted
//   DONE   | result/carry_out held and presented until done_ready
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start_valid  producer request
//   start_ready  request can be accepted (IDLE only)
//   op           00=LSL 01=LSR 10=ASR 11=ROR, sampled at accept
//   amount       shift count, sampled at accept
//   data_in      operand, sampled at accept
//   carry_in     C flag, passed through unchanged when amount==0
//   result       shifted operand, valid while done_valid
//   carry_out    last bit shifted out
//   done_valid   result/carry_out valid
//   done_ready   consumer takes the result
//   busy         SHIFT or DONE
module serial_shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [AMT_W-1:0] cnt;
    logic             accept;
    logic [WIDTH-1:0] shift_res;
    logic             shift_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_valid) begin
                    accept    = 1'b1;
                    state_nxt = (amount == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == AMT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single-bit shift stage; amounts >= WIDTH need no special case because
    // repeated application naturally saturates (LSL/LSR/ASR) or wraps (ROR).
    always_comb begin
        shift_res = result;
        shift_c   = carry_out;
        case (op_q)
            OP_LSL: begin
                shift_c   = result[WIDTH-1];
                shift_res = {result[WIDTH-2:0], 1'b0};
            end
            OP_LSR: begin
                shift_c   = result[0];
                shift_res = {1'b0, result[WIDTH-1:1]};
            end
            OP_ASR: begin
                shift_c   = result[0];
                shift_res = {result[WIDTH-1], result[WIDTH-1:1]};
            end
            OP_ROR: begin
                shift_c   = result[0];
                shift_res = {result[0], result[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= OP_LSL;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            op_q      <= op;
            cnt       <= amount;
            result    <= data_in;
            carry_out <= carry_in;
        end else if (state == S_SHIFT) begin
            cnt       <= cnt - AMT_W'(1);
            result    <= shift_res;
            carry_out <= shift_c;
        end
    end

    assign start_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done_valid  = (state == S_DONE);

endmodule
